// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad PIN controller: key codes, FSM states, digit helper.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_key_event.sv
// Press/release detector: turns repeated scanner reports into one press event per key press.
module keypad_key_event #(
  parameter int RELEASE_CYC = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] key_evt_code
);
  localparam int RW = $clog2(RELEASE_CYC + 1);

  logic          held;
  logic [3:0]    held_code;
  logic [RW-1:0] rel_cnt;
  logic          press;

  assign press = key_valid && (!held || key_code != held_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held         <= 1'b0;
      held_code    <= '0;
      rel_cnt      <= '0;
      key_evt      <= 1'b0;
      key_evt_code <= '0;
    end else if (flush) begin
      held    <= 1'b0;
      rel_cnt <= '0;
      key_evt <= 1'b0;
    end else begin
      key_evt <= press;
      if (press) key_evt_code <= key_code;
      // Any report, new or repeated, keeps the key held and restarts the release timer.
      if (key_valid) begin
        held      <= 1'b1;
        held_code <= key_code;
        rel_cnt   <= '0;
      end else if (held) begin
        if (rel_cnt == RW'(RELEASE_CYC - 1)) begin
          held    <= 1'b0;
          rel_cnt <= '0;
        end else begin
          rel_cnt <= rel_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_pin_ctrl.sv
// PIN entry controller with timed unlock and consecutive-failure tracking.
// Define KEYPAD_PIN_LOCKOUT_EN to add a LOCKOUT state after MAX_FAIL consecutive failures.
module keypad_pin_ctrl
  import keypad_pkg::*;
#(
  parameter int PIN_LEN      = 4,
  parameter int RELEASE_CYC  = 160,
  parameter int ENTRY_TO_CYC = 65535,
  parameter int UNLOCK_CYC   = 65535,
  parameter int MAX_FAIL     = 3,
  parameter int LOCKOUT_CYC  = 65535
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  input  logic [4*PIN_LEN-1:0]            pin_cfg,
  output logic                            scan_en,
  output logic                            key_evt,
  output logic [3:0]                      key_evt_code,
  output logic [3:0]                      entry_cnt,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic                            fail_pulse,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);
  localparam int EW   = 4 * PIN_LEN;
  localparam int FW   = $clog2(MAX_FAIL + 1);
  localparam int TM1  = (ENTRY_TO_CYC > UNLOCK_CYC) ? ENTRY_TO_CYC : UNLOCK_CYC;
  localparam int TMAX = (TM1 > LOCKOUT_CYC) ? TM1 : LOCKOUT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        state, next_state;
  logic [TW-1:0] tmr;
  logic [EW-1:0] entry;
  logic          ovf, flush, match, lock_trip, dig_evt;
  logic          tmr_clr, unlocked_d, fail_d;
  logic [FW-1:0] fail_inc;

  keypad_key_event #(.RELEASE_CYC(RELEASE_CYC)) u_key_event (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_evt      (key_evt),
    .key_evt_code (key_evt_code)
  );

  assign dig_evt  = key_evt && is_digit(key_evt_code);
  assign match    = (entry_cnt == 4'(PIN_LEN)) && !ovf && (entry == pin_cfg);
  assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

`ifdef KEYPAD_PIN_LOCKOUT_EN
  logic locked_d;
  assign lock_trip = (fail_inc == FW'(MAX_FAIL));
  assign flush     = (state == ST_LOCKOUT);
`else
  assign lock_trip  = 1'b0;
  assign flush      = 1'b0;
  assign locked_out = 1'b0;
  assign scan_en    = 1'b1;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (dig_evt) next_state = ST_ENTRY;
      ST_ENTRY: begin
        if (key_evt && key_evt_code == KEY_STAR)      next_state = ST_IDLE;
        else if (key_evt && key_evt_code == KEY_HASH) next_state = ST_CHECK;
        else if (!key_evt && tmr == TW'(ENTRY_TO_CYC - 1)) next_state = ST_IDLE;
      end
      ST_CHECK: begin
        if (match)          next_state = ST_UNLOCKED;
        else if (lock_trip) next_state = ST_LOCKOUT;
        else                next_state = ST_IDLE;
      end
      ST_UNLOCKED: begin
        if (key_evt && key_evt_code == KEY_A)    next_state = ST_IDLE;
        else if (tmr == TW'(UNLOCK_CYC - 1))     next_state = ST_IDLE;
      end
`ifdef KEYPAD_PIN_LOCKOUT_EN
      ST_LOCKOUT:  if (tmr == TW'(LOCKOUT_CYC - 1)) next_state = ST_IDLE;
`endif
      default:     next_state = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from next_state so they line up with the state register.
  always_comb begin
    unlocked_d = (next_state == ST_UNLOCKED);
    fail_d     = (state == ST_CHECK) && !match;
    tmr_clr    = (next_state != state) || (state == ST_ENTRY && key_evt);
`ifdef KEYPAD_PIN_LOCKOUT_EN
    locked_d   = (next_state == ST_LOCKOUT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      unlocked   <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      state      <= next_state;
      tmr        <= tmr_clr ? '0 : tmr + 1'b1;
      unlocked   <= unlocked_d;
      fail_pulse <= fail_d;
    end
  end

`ifdef KEYPAD_PIN_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_out <= 1'b0;
      scan_en    <= 1'b1;
    end else begin
      locked_out <= locked_d;
      scan_en    <= !locked_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      entry_cnt <= '0;
      ovf       <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (dig_evt) begin
          entry     <= EW'(key_evt_code);
          entry_cnt <= 4'd1;
          ovf       <= 1'b0;
        end
        ST_ENTRY: begin
          if (dig_evt) begin
            entry <= (entry << 4) | EW'(key_evt_code);
            if (entry_cnt != 4'hF) entry_cnt <= entry_cnt + 4'd1;
            if (entry_cnt >= 4'(PIN_LEN)) ovf <= 1'b1;
          end else if (next_state == ST_IDLE) begin
            entry     <= '0;
            entry_cnt <= '0;
            ovf       <= 1'b0;
          end
        end
        ST_CHECK: begin
          entry     <= '0;
          entry_cnt <= '0;
          ovf       <= 1'b0;
          fail_cnt  <= match ? '0 : fail_inc;
        end
        ST_LOCKOUT: if (next_state == ST_IDLE) fail_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
